// File: rtl/sseg_pager.sv
// Multi-channel hex pager for a DIGITS-digit seven-segment display: captures
// CHANNELS words, pages manually/automatically, blinks digits that just changed.
module sseg_pager #(
  parameter int DIGITS     = 8,
  parameter int CHANNELS   = 4,
  parameter int DWELL      = 50_000_000,
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic                          I_CLK,
  input  logic                          I_RSTF,
  input  logic [CHANNELS*4*DIGITS-1:0]  I_DATA,
  input  logic [CHANNELS-1:0]           I_VALID,
  input  logic [1:0]                    I_MODE,
  input  logic                          I_NEXTF,
  input  logic                          I_LZB,
  output logic [7*DIGITS-1:0]           O_SSEG,
  output logic [$clog2(CHANNELS)-1:0]   O_PAGE,
  output logic [CHANNELS-1:0]           O_NEW
);
  localparam int DW = 4 * DIGITS;
  localparam int PW = $clog2(CHANNELS);
  localparam int CW = $clog2(DWELL);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(CHANNELS - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {S_MANUAL, S_AUTO, S_HOLD} state_t;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  logic                nxt_p0, nxt_p1, nxt_p2;
  logic                adv;
  state_t              st, mode_nx;
  logic [PW-1:0]       page, page_inc, page_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [DW-1:0]       snap [CHANNELS];
  logic [DW-1:0]       cap, cur;
  logic [DIGITS-1:0]   mask, diff;
  logic [BW-1:0]       bcnt;
  logic                phase;
  logic [7*DIGITS-1:0] sseg_nx;
  logic                lead;
  logic [3:0]          nib;

  // Pushbutton synchroniser; the third flop only serves falling-edge detection.
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      nxt_p0 <= 1'b1;
      nxt_p1 <= 1'b1;
      nxt_p2 <= 1'b1;
    end else begin
      nxt_p0 <= I_NEXTF;
      nxt_p1 <= nxt_p0;
      nxt_p2 <= nxt_p1;
    end
  end

  assign adv      = nxt_p2 & ~nxt_p1;
  assign page_inc = (page == PAGE_LAST) ? '0 : page + PW'(1);

  always_comb begin
    case (I_MODE)
      2'd0:    mode_nx = S_MANUAL;
      2'd1:    mode_nx = S_AUTO;
      default: mode_nx = S_HOLD;
    endcase
  end

  // A single page step per cycle even when terminal count and a press coincide.
  always_comb begin
    page_nx = page;
    cnt_nx  = '0;
    case (mode_nx)
      S_MANUAL: if (adv) page_nx = page_inc;
      S_AUTO: begin
        if (adv || (st == S_AUTO && cnt == DWELL_LAST)) page_nx = page_inc;
        else cnt_nx = (st == S_AUTO) ? cnt + CW'(1) : CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      st   <= S_HOLD;
      page <= '0;
      cnt  <= '0;
    end else begin
      st   <= mode_nx;
      page <= page_nx;
      cnt  <= cnt_nx;
    end
  end

  assign O_PAGE = page;
  assign cap    = I_DATA[page*DW +: DW];
  assign cur    = snap[page];

  always_comb begin
    diff = '0;
    for (int d = 0; d < DIGITS; d++) diff[d] = (cap[4*d +: 4] != cur[4*d +: 4]);
  end

  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      for (int c = 0; c < CHANNELS; c++) snap[c] <= '0;
      O_NEW <= '0;
      mask  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (I_VALID[c]) snap[c] <= I_DATA[c*DW +: DW];
        if (page_nx == PW'(c)) O_NEW[c] <= 1'b0;
        else if (I_VALID[c])   O_NEW[c] <= 1'b1;
      end
      if (page_nx != page)     mask <= '0;
      else if (I_VALID[page])  mask <= mask | diff;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + BW'(1);
    end
  end

  // Scan from the top digit so leading-zero blanking stops at the first non-zero.
  always_comb begin
    sseg_nx = '1;
    lead    = I_LZB;
    nib     = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = cur[4*d +: 4];
      if ((lead && nib == 4'h0 && d != 0) || (phase && mask[d]))
        sseg_nx[7*d +: 7] = 7'h7F;
      else
        sseg_nx[7*d +: 7] = hex_seg(nib);
      if (nib != 4'h0) lead = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) O_SSEG <= '1;
    else         O_SSEG <= sseg_nx;
  end

endmodule
